// File: rtl/prf_multiport.sv
// Physical register file with registered multi-port reads, writeback bypass,
// a readiness scoreboard and a post-reset scrubber that zeroes the storage.
module prf_multiport #(
  parameter int PHY_REGS   = 64,
  parameter int PHY_WIDTH  = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 6,
  parameter int NUM_WB     = 3,
  parameter int NUM_ALLOC  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             flush,
  output logic                             init_done,
  input  logic [NUM_ALLOC-1:0]             alloc_en,
  input  logic [NUM_ALLOC*PHY_WIDTH-1:0]   alloc_preg,
  input  logic [NUM_RD-1:0]                rd_en,
  input  logic [NUM_RD*PHY_WIDTH-1:0]      rd_preg,
  output logic [NUM_RD-1:0]                rd_valid,
  output logic [NUM_RD*DATA_WIDTH-1:0]     rd_data,
  input  logic [NUM_WB-1:0]                wb_en,
  input  logic [NUM_WB*PHY_WIDTH-1:0]      wb_preg,
  input  logic [NUM_WB*DATA_WIDTH-1:0]     wb_data,
  output logic [PHY_REGS-1:0]              prf_ready,
  output logic [PHY_REGS*DATA_WIDTH-1:0]   prf_data_out
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                       state_q, state_d;
  logic [PHY_WIDTH:0]           init_ptr_q, init_ptr_d;
  logic [DATA_WIDTH-1:0]        mem_q [PHY_REGS];
  logic [DATA_WIDTH-1:0]        mem_d [PHY_REGS];
  logic [PHY_REGS-1:0]          ready_q, ready_d;
  logic [NUM_RD-1:0]            rd_valid_q, rd_valid_d;
  logic [NUM_RD*DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [DATA_WIDTH-1:0]        rd_val [NUM_RD];
  logic                         run;

  assign run       = (state_q == ST_RUN);
  assign init_done = run;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign prf_ready = ready_q;

  for (genvar i = 0; i < PHY_REGS; i++) begin : g_dbg
    assign prf_data_out[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[i];
  end

  // Operand value per read port: array, overridden by a matching writeback
  // (later ports override earlier ones), with preg 0 forced to zero.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      rd_val[k] = mem_q[rd_preg[k*PHY_WIDTH +: PHY_WIDTH]];
      for (int w = 0; w < NUM_WB; w++) begin
        if (wb_en[w] && (wb_preg[w*PHY_WIDTH +: PHY_WIDTH] == rd_preg[k*PHY_WIDTH +: PHY_WIDTH]))
          rd_val[k] = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_preg[k*PHY_WIDTH +: PHY_WIDTH] == '0)
        rd_val[k] = '0;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    mem_d      = mem_q;
    ready_d    = ready_q;
    rd_valid_d = '0;
    rd_data_d  = rd_data_q;
    case (state_q)
      ST_INIT: begin
        mem_d[init_ptr_q[PHY_WIDTH-1:0]] = '0;
        init_ptr_d = init_ptr_q + (PHY_WIDTH+1)'(1);
        if (init_ptr_q == (PHY_WIDTH+1)'(PHY_REGS-1))
          state_d = ST_RUN;
      end
      default: begin
        for (int k = 0; k < NUM_RD; k++) begin
          if (rd_en[k] && !flush) begin
            rd_valid_d[k] = 1'b1;
            rd_data_d[k*DATA_WIDTH +: DATA_WIDTH] = rd_val[k];
          end
        end
        for (int w = 0; w < NUM_WB; w++) begin
          if (wb_en[w] && (wb_preg[w*PHY_WIDTH +: PHY_WIDTH] != '0))
            mem_d[wb_preg[w*PHY_WIDTH +: PHY_WIDTH]] = wb_data[w*DATA_WIDTH +: DATA_WIDTH];
        end
        // Allocation is applied after writeback so a same-cycle alloc wins.
        if (flush) begin
          ready_d = '1;
        end else begin
          for (int w = 0; w < NUM_WB; w++) begin
            if (wb_en[w])
              ready_d[wb_preg[w*PHY_WIDTH +: PHY_WIDTH]] = 1'b1;
          end
          for (int a = 0; a < NUM_ALLOC; a++) begin
            if (alloc_en[a] && (alloc_preg[a*PHY_WIDTH +: PHY_WIDTH] != '0))
              ready_d[alloc_preg[a*PHY_WIDTH +: PHY_WIDTH]] = 1'b0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ready_q    <= '1;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      ready_q    <= ready_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage has no reset; the scrubber clears it after every reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_prf_multiport.sv
// Bench for prf_multiport: directed steps plus random traffic, checked against
// an array-based model of the register file and its ready scoreboard.
module tb_prf_multiport;
  localparam int PR = 64, PW = 6, DW = 32, NR = 6, NW = 3, NA = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               flush;
  logic               init_done;
  logic [NA-1:0]      alloc_en;
  logic [NA*PW-1:0]   alloc_preg;
  logic [NR-1:0]      rd_en;
  logic [NR*PW-1:0]   rd_preg;
  logic [NR-1:0]      rd_valid;
  logic [NR*DW-1:0]   rd_data;
  logic [NW-1:0]      wb_en;
  logic [NW*PW-1:0]   wb_preg;
  logic [NW*DW-1:0]   wb_data;
  logic [PR-1:0]      prf_ready;
  logic [PR*DW-1:0]   prf_data_out;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] m_mem [PR];
  logic [PR-1:0] m_ready;
  logic [NR-1:0] m_valid;
  logic [DW-1:0] m_rdata [NR];
  bit            m_run;
  int            m_cnt;

  prf_multiport #(.PHY_REGS(PR), .PHY_WIDTH(PW), .DATA_WIDTH(DW),
                  .NUM_RD(NR), .NUM_WB(NW), .NUM_ALLOC(NA)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .init_done(init_done),
    .alloc_en(alloc_en), .alloc_preg(alloc_preg),
    .rd_en(rd_en), .rd_preg(rd_preg), .rd_valid(rd_valid), .rd_data(rd_data),
    .wb_en(wb_en), .wb_preg(wb_preg), .wb_data(wb_data),
    .prf_ready(prf_ready), .prf_data_out(prf_data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    flush = 1'b0; alloc_en = '0; alloc_preg = '0; rd_en = '0; rd_preg = '0;
    wb_en = '0; wb_preg = '0; wb_data = '0;
  endtask

  task automatic set_wb(input int w, input int preg, input logic [DW-1:0] d);
    wb_en[w] = 1'b1; wb_preg[w*PW +: PW] = PW'(preg); wb_data[w*DW +: DW] = d;
  endtask

  task automatic set_rd(input int k, input int preg);
    rd_en[k] = 1'b1; rd_preg[k*PW +: PW] = PW'(preg);
  endtask

  task automatic set_alloc(input int a, input int preg);
    alloc_en[a] = 1'b1; alloc_preg[a*PW +: PW] = PW'(preg);
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_ready = '1; m_valid = '0;
    for (int k = 0; k < NR; k++) m_rdata[k] = '0;
    for (int i = 0; i < PR; i++) m_mem[i] = '0;
  endtask

  // One clock of behaviour: reads see the old array plus the newest matching
  // writeback; then writes land, then ready bits move (alloc after wb).
  task automatic model_step();
    int p;
    logic [DW-1:0] v;
    if (!m_run) begin
      m_cnt++;
      m_valid = '0;
      if (m_cnt == PR) m_run = 1;
      return;
    end
    for (int k = 0; k < NR; k++) begin
      m_valid[k] = rd_en[k] && !flush;
      if (m_valid[k]) begin
        p = int'(rd_preg[k*PW +: PW]);
        v = m_mem[p];
        for (int w = 0; w < NW; w++)
          if (wb_en[w] && int'(wb_preg[w*PW +: PW]) == p) v = wb_data[w*DW +: DW];
        m_rdata[k] = (p == 0) ? '0 : v;
      end
    end
    for (int w = 0; w < NW; w++) begin
      p = int'(wb_preg[w*PW +: PW]);
      if (wb_en[w] && p != 0) m_mem[p] = wb_data[w*DW +: DW];
    end
    if (flush) m_ready = '1;
    else begin
      for (int w = 0; w < NW; w++) if (wb_en[w]) m_ready[wb_preg[w*PW +: PW]] = 1'b1;
      for (int a = 0; a < NA; a++) begin
        p = int'(alloc_preg[a*PW +: PW]);
        if (alloc_en[a] && p != 0) m_ready[p] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("init_done", 64'(init_done), 64'(m_run));
    chk("rd_valid", 64'(rd_valid), 64'(m_valid));
    for (int k = 0; k < NR; k++)
      if (m_valid[k]) chk($sformatf("rd_data[%0d]", k), 64'(rd_data[k*DW +: DW]), 64'(m_rdata[k]));
    chk("prf_ready", prf_ready, m_ready);
  endtask

  // Inputs are driven at negedge; outputs are compared 1ns after the posedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_init_done", 64'(init_done), 64'd0);
    chk("reset_ready", prf_ready, {PR{1'b1}});
    chk("reset_rd_valid", 64'(rd_valid), 64'd0);
    for (int k = 0; k < NR; k++) chk("reset_rd_data", 64'(rd_data[k*DW +: DW]), 64'd0);
    rst_n = 1'b1;

    // Scrub: reads requested during INIT must not produce valid data
    set_rd(0, 5);
    for (int i = 1; i <= PR; i++) begin
      tick();
      chk("init_wait", 64'(init_done), 64'(i == PR));
      if (i < PR) chk("init_rd_valid", 64'(rd_valid[0]), 64'd0);
    end
    clear_inputs();
    set_rd(0, 5);
    tick();
    chk("scrub_read_valid", 64'(rd_valid[0]), 64'd1);
    chk("scrub_read_data", 64'(rd_data[DW-1:0]), 64'd0);

    // Write then read
    clear_inputs(); set_wb(0, 7, 32'hDEADBEEF); tick();
    chk("wb_ready7", 64'(prf_ready[7]), 64'd1);
    chk("dbg_image7", 64'(prf_data_out[7*DW +: DW]), 64'hDEADBEEF);
    clear_inputs(); set_rd(0, 7); tick();
    chk("read7", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);

    // Bypass: single and competing writebacks
    clear_inputs(); set_wb(2, 9, 32'h1234); set_rd(3, 9); tick();
    chk("bypass_single", 64'(rd_data[3*DW +: DW]), 64'h1234);
    clear_inputs(); set_wb(1, 9, 32'h77); tick();
    clear_inputs(); set_wb(0, 9, 32'hAAAA); set_wb(2, 9, 32'h1234); set_rd(3, 9); tick();
    chk("bypass_multi", 64'(rd_data[3*DW +: DW]), 64'h1234);
    clear_inputs(); set_rd(4, 9); tick();
    chk("multi_write", 64'(rd_data[4*DW +: DW]), 64'h1234);

    // Scoreboard race
    clear_inputs(); set_alloc(0, 12); tick();
    chk("alloc12", 64'(prf_ready[12]), 64'd0);
    clear_inputs(); set_alloc(1, 12); set_wb(1, 12, 32'h5); tick();
    chk("alloc_wb12", 64'(prf_ready[12]), 64'd0);
    clear_inputs(); set_wb(2, 12, 32'h6); tick();
    chk("wb12", 64'(prf_ready[12]), 64'd1);

    // Preg 0
    clear_inputs(); set_wb(0, 0, 32'hFFFF); tick();
    clear_inputs(); set_rd(2, 0); tick();
    chk("preg0_valid", 64'(rd_valid[2]), 64'd1);
    chk("preg0_data", 64'(rd_data[2*DW +: DW]), 64'd0);
    clear_inputs(); set_alloc(0, 0); tick();
    chk("preg0_ready", 64'(prf_ready[0]), 64'd1);

    // Flush: ready all set, same-cycle alloc ignored, read killed, wb still writes
    clear_inputs(); set_alloc(0, 20); set_alloc(1, 21); tick();
    chk("alloc20", 64'(prf_ready[20]), 64'd0);
    chk("alloc21", 64'(prf_ready[21]), 64'd0);
    clear_inputs(); flush = 1'b1; set_rd(1, 7); set_alloc(0, 25); set_wb(0, 30, 32'hCAFE); tick();
    chk("flush_ready20", 64'(prf_ready[20]), 64'd1);
    chk("flush_ready21", 64'(prf_ready[21]), 64'd1);
    chk("flush_alloc25", 64'(prf_ready[25]), 64'd1);
    chk("flush_rd_valid", 64'(rd_valid[1]), 64'd0);
    clear_inputs(); set_rd(5, 30); tick();
    chk("flush_wb_data", 64'(rd_data[5*DW +: DW]), 64'hCAFE);

    // Random traffic; writeback pregs kept distinct per cycle
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      flush = ($urandom_range(0, 15) == 0);
      for (int a = 0; a < NA; a++)
        if ($urandom_range(0, 2) == 0) set_alloc(a, $urandom_range(0, 23));
      for (int w = 0; w < NW; w++)
        if ($urandom_range(0, 1) == 1) set_wb(w, ($urandom_range(0, 7) * 3 + w) % PR, $urandom);
      for (int k = 0; k < NR; k++)
        if ($urandom_range(0, 1) == 1) set_rd(k, $urandom_range(0, 23));
      tick();
    end

    // Reset in RUN restarts the scrub
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("rerst_init_done", 64'(init_done), 64'd0);
    chk("rerst_ready", prf_ready, {PR{1'b1}});
    chk("rerst_rd_valid", 64'(rd_valid), 64'd0);
    for (int k = 0; k < NR; k++) chk("rerst_rd_data", 64'(rd_data[k*DW +: DW]), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= PR; i++) begin
      tick();
      chk("rescrub_wait", 64'(init_done), 64'(i == PR));
    end
    clear_inputs(); set_rd(0, 7); set_rd(1, 9); tick();
    chk("rescrub_read7", 64'(rd_data[DW-1:0]), 64'd0);
    chk("rescrub_read9", 64'(rd_data[DW +: DW]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prf_multiport.md
Name: prf_multiport

Overview:
- Parametrised physical register file with a readiness scoreboard for the out-of-order core.
- Provides NUM_RD registered read ports with same-cycle writeback bypass, NUM_WB writeback ports and NUM_ALLOC rename-allocation ports.
- A sequential init scrubber clears the data array after reset, so no async reset is needed on the storage.
- Sits between rename/issue (alloc, ready query, operand read) and the execution writeback buses.

Parameters:
- PHY_REGS, 64, number of physical registers (power of two, at least 4).
- PHY_WIDTH, 6, preg index width, equal to log2(PHY_REGS).
- DATA_WIDTH, 32, register data width.
- NUM_RD, 6, operand read ports.
- NUM_WB, 3, writeback ports.
- NUM_ALLOC, 2, rename allocation ports per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  pipeline flush, synchronous.
- init_done  out  1  scrub complete; block accepts traffic.
- alloc_en  in  NUM_ALLOC  allocation valid per port.
- alloc_preg  in  NUM_ALLOC*PHY_WIDTH  newly allocated destination pregs.
- rd_en  in  NUM_RD  read request per port.
- rd_preg  in  NUM_RD*PHY_WIDTH  read addresses.
- rd_valid  out  NUM_RD  read data valid, one cycle after request.
- rd_data  out  NUM_RD*DATA_WIDTH  read data.
- wb_en  in  NUM_WB  writeback valid per port.
- wb_preg  in  NUM_WB*PHY_WIDTH  writeback destination.
- wb_data  in  NUM_WB*DATA_WIDTH  writeback data.
- prf_ready  out  PHY_REGS  1 means the preg's value has been produced.
- prf_data_out  out  PHY_REGS*DATA_WIDTH  debug flat image of the array.

Behaviour:
- **Reset values** (rst_n low, async):
  - FSM = INIT, init_ptr = 0, init_done = 0.
  - prf_ready = all 1s.
  - rd_valid = 0, rd_data = 0.
  - The data array is not reset.
- **FSM INIT**:
  - Each cycle writes 0 to entry init_ptr, then increments init_ptr.
  - After the write to entry PHY_REGS-1, moves to RUN next cycle and sets init_done = 1 (PHY_REGS cycles after reset release).
  - While in INIT, alloc, wb, rd and flush are ignored and rd_valid stays 0.
- **FSM RUN**: stays in RUN until reset. A reset asserted mid-INIT or mid-RUN returns the FSM to INIT and restarts the scrub from 0.
- **Preg 0**:
  - Hardwired zero: reads return 0.
  - Writes to preg 0 are dropped.
  - Allocation never clears ready[0].
- **Read**:
  - rd_en[k] sampled at edge t gives rd_valid[k] = 1 and rd_data[k] at t+1 (registered, latency 1).
  - rd_en[k] = 0 gives rd_valid[k] = 0 next cycle; rd_data[k] holds its previous value.
- **Bypass**:
  - If any wb port in the same cycle as the read has wb_en and wb_preg equal to rd_preg (nonzero), rd_data takes that wb_data instead of the array value.
  - If several wb ports match, the highest-index port wins.
- **Write**:
  - wb_en[w] writes wb_data into the array at the edge.
  - Duplicate wb_preg values in one cycle are illegal; the highest index wins deterministically.
- **Scoreboard**:
  - wb_en[w] sets ready[wb_preg] = 1.
  - alloc_en[a] clears ready[alloc_preg] = 0.
  - If alloc and wb target the same preg in the same cycle, alloc wins and ready ends at 0.
  - prf_ready is the registered bit vector, updated at the edge.
- **Flush** (RUN only):
  - At the edge all ready bits are set to 1.
  - alloc in the flush cycle is ignored.
  - wb in the flush cycle still writes data.
  - rd_valid is forced to 0 the next cycle, killing in-flight reads.
- **Widths**: all ports are flat vectors, port k occupying bits [(k+1)*W-1 -: W]. No arithmetic other than the init_ptr increment, which is PHY_WIDTH+1 bits wide so the terminal compare never wraps.

Test Plan:
- **Init scrub**: release rst_n with default params → init_done stays 0 for 64 cycles and goes 1 on cycle 64; a read of preg 5 returns 0 with rd_valid=1 one cycle later; rd_en asserted during INIT gives rd_valid=0.
- **Write then read**: wb preg 7 = 0xDEADBEEF; next cycle rd_en[0] on preg 7 → rd_data[0] = 0xDEADBEEF at +1; ready[7] = 1.
- **Bypass**: wb[2] to preg 9 = 0x1234 and rd_en[3] on preg 9 in the same cycle → rd_data[3] = 0x1234 next cycle; wb[0] and wb[2] both to preg 9 (0xAAAA, 0x1234) → 0x1234.
- **Scoreboard race**: alloc preg 12 → ready[12] = 0; alloc and wb to preg 12 in the same cycle → ready[12] = 0; a later wb alone → ready[12] = 1.
- **Preg 0**: wb preg 0 = 0xFFFF then read → 0; alloc preg 0 → ready[0] stays 1.
- **Flush and reset**:
  - Alloc pregs 20 and 21, then flush with rd_en[1] pending → ready[20] = ready[21] = 1 and rd_valid[1] = 0 next cycle.
  - Assert rst_n low mid-RUN → init_done = 0 immediately, and the scrub repeats for 64 cycles.
